// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte FIFO with write sequencer that feeds the UART one byte at a time
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  tx_timeout,
    output logic                  uart_wr,
    output logic [DATA_W-1:0]     uart_dat,
    input  logic                  uart_busy
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                push_ok;
    logic                pop;
    logic                timeout_hit;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                     (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign level   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        uart_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !uart_busy) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                uart_wr   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                // A byte whose busy never shows up is treated as sent; no retry.
                if (uart_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CW'(BUSY_WAIT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            uart_dat   <= '0;
            overflow   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                uart_dat <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (timeout_hit) begin
                tx_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

endmodule
